// File: rtl/fan_ctrl_pkg.sv
// Shared types for the fan controller: FSM state encoding, PWM duty levels, small helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fan_ctrl_pkg;

  // Fan FSM states; the four fan levels keep their level number in bits [1:0].
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_LOW   = 3'd1,
    ST_MID   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_ALARM = 3'd4
  } fan_state_t;

  // PWM duty in 16ths of a period; 16 means the output never drops.
  localparam logic [4:0] DUTY_OFF  = 5'd0;
  localparam logic [4:0] DUTY_LOW  = 5'd6;
  localparam logic [4:0] DUTY_MID  = 5'd11;
  localparam logic [4:0] DUTY_FULL = 5'd16;

  // Duty applied for a given state; ALARM runs the fan flat out like HIGH.
  function automatic logic [4:0] duty_for(input fan_state_t s);
    logic [4:0] d;
    case (s)
      ST_OFF:  d = DUTY_OFF;
      ST_LOW:  d = DUTY_LOW;
      ST_MID:  d = DUTY_MID;
      default: d = DUTY_FULL;
    endcase
    return d;
  endfunction

  // Reported fan level; ALARM reports the top level.
  function automatic logic [1:0] level_of(input fan_state_t s);
    logic [1:0] l;
    if (s == ST_ALARM) begin
      l = 2'd3;
    end else begin
      l = s[1:0];
    end
    return l;
  endfunction

endpackage

// File: rtl/fan_pwm.sv
// PWM generator: free-running 4-bit phase counter compared against a 5-bit duty.
// Latency: output registered, a duty change shows on the edge after it is applied.
// Backpressure: none; runs every cycle.
module fan_pwm (
  input  logic       clk,
  input  logic       rstN,
  input  logic [4:0] duty,
  output logic       fanPwm
);

  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_q, pwm_d;

  // Next phase and next output level; 5-bit compare lets duty 16 stay high all period.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    pwm_d     = ({1'b0, pwm_cnt_q} < duty);
  end

  // Phase counter and registered output.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pwm_cnt_q <= 4'd0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign fanPwm = pwm_q;

endmodule

// File: rtl/fan_control_unit.sv
// Fan controller: zone hysteresis, multi-sample confirmation, latched over-temp alarm, PWM drive.
// Latency: fanSpeed/alarm update on the edge capturing the deciding sample or ack; fanPwm one edge later.
// Backpressure: none; every qualified sample is consumed in the cycle it arrives.
module fan_control_unit
  import fan_ctrl_pkg::*;
#(
  parameter logic [7:0] T_LOW   = 8'd30,
  parameter logic [7:0] T_MID   = 8'd40,
  parameter logic [7:0] T_HIGH  = 8'd50,
  parameter logic [7:0] T_ALARM = 8'd70,
  parameter logic [7:0] HYST    = 8'd4,
  parameter int         CONFIRM = 3
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] temperature,
  input  logic       tempValid,
  input  logic       alarmAck,
  output logic [1:0] fanSpeed,
  output logic       fanPwm,
  output logic       alarm
);

  // Downward thresholds are fixed at elaboration; every threshold exceeds HYST.
  localparam logic [7:0] T_LOW_DN   = T_LOW   - HYST;
  localparam logic [7:0] T_MID_DN   = T_MID   - HYST;
  localparam logic [7:0] T_HIGH_DN  = T_HIGH  - HYST;
  localparam logic [7:0] T_ALARM_DN = T_ALARM - HYST;

  localparam int              CNT_W   = $clog2(CONFIRM + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CONFIRM);

  fan_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       prev_tgt_q, prev_tgt_d;
  logic [7:0]       last_q, last_d;
  logic [1:0]       fan_speed_q, fan_speed_d;
  logic             alarm_q, alarm_d;

  logic [1:0]       zone_up, zone_dn, lvl, tgt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       exit_temp;
  logic [4:0]       duty;

  // Zone counts for the current sample and the level it asks for from the present state.
  always_comb begin
    zone_up = {1'b0, (temperature >= T_LOW)}
            + {1'b0, (temperature >= T_MID)}
            + {1'b0, (temperature >= T_HIGH)};
    zone_dn = {1'b0, (temperature >= T_LOW_DN)}
            + {1'b0, (temperature >= T_MID_DN)}
            + {1'b0, (temperature >= T_HIGH_DN)};
    lvl = level_of(state_q);
    if (zone_up > lvl) begin
      tgt = zone_up;
    end else if (zone_dn < lvl) begin
      tgt = zone_dn;
    end else begin
      tgt = lvl;
    end
  end

  // Next-state logic: alarm entry/exit, confirmation run, registered output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_tgt_d = prev_tgt_q;
    last_d     = last_q;
    cnt_nxt    = '0;

    if (tempValid) begin
      last_d = temperature;
    end
    // A sample arriving with the ack is the one the exit decision must see.
    exit_temp = tempValid ? temperature : last_q;

    if (state_q == ST_ALARM) begin
      if (alarmAck && (exit_temp < T_ALARM_DN)) begin
        state_d = ST_HIGH;
        cnt_d   = '0;
      end
    end else if (tempValid) begin
      if (temperature >= T_ALARM) begin
        state_d = ST_ALARM;
        cnt_d   = '0;
      end else begin
        prev_tgt_d = tgt;
        if (tgt == lvl) begin
          cnt_d = '0;
        end else begin
          // A changed target starts a fresh run that already counts this sample.
          if (tgt != prev_tgt_q) begin
            cnt_nxt = CNT_W'(1);
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
          if (cnt_nxt == CNT_TOP) begin
            state_d = fan_state_t'({1'b0, tgt});
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_nxt;
          end
        end
      end
    end

    fan_speed_d = level_of(state_d);
    alarm_d     = (state_d == ST_ALARM);
  end

  // FSM state, confirmation bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      prev_tgt_q  <= 2'd0;
      last_q      <= 8'd0;
      fan_speed_q <= 2'd0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_tgt_q  <= prev_tgt_d;
      last_q      <= last_d;
      fan_speed_q <= fan_speed_d;
      alarm_q     <= alarm_d;
    end
  end

  assign duty     = duty_for(state_q);
  assign fanSpeed = fan_speed_q;
  assign alarm    = alarm_q;

  fan_pwm u_pwm (
    .clk    (clk),
    .rstN   (rstN),
    .duty   (duty),
    .fanPwm (fanPwm)
  );

endmodule

// File: tb/tb_fan_control_unit.sv
module tb_fan_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] temperature;
  logic       temp_valid;
  logic       alarm_ack;
  logic [1:0] fan_speed;
  logic       fan_pwm;
  logic       alarm;

  always #5 clk = ~clk;

  fan_control_unit dut (
    .clk         (clk),
    .rstN        (rst_n),
    .temperature (temperature),
    .tempValid   (temp_valid),
    .alarmAck    (alarm_ack),
    .fanSpeed    (fan_speed),
    .fanPwm      (fan_pwm),
    .alarm       (alarm)
  );

  typedef struct packed {
    logic [1:0]  spd;
    logic        alm;
    logic        pchk;
    logic        pwm;
    logic [15:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;
  int   high_cnt;

  task automatic chk(input string nm, input int tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s (vec %0d): got %0d want %0d", nm, tag, got, want);
    end
  endtask

  // One stimulus cycle: drive at negedge, queue the outputs expected after the next posedge.
  task automatic cyc(input logic rn, input logic [7:0] t, input logic v, input logic ack,
                     input logic [1:0] es, input logic ea, input logic pc, input logic ep);
    exp_t e;
    @(negedge clk);
    rst_n       = rn;
    temperature = t;
    temp_valid  = v;
    alarm_ack   = ack;
    e.spd  = es;
    e.alm  = ea;
    e.pchk = pc;
    e.pwm  = ep;
    e.tag  = 16'(vec);
    vec++;
    exp_q.push_back(e);
  endtask

  // Valid sample, no ack, no PWM check.
  task automatic smp(input logic [7:0] t, input logic [1:0] es, input logic ea);
    cyc(1'b1, t, 1'b1, 1'b0, es, ea, 1'b0, 1'b0);
  endtask

  // Invalid cycle with no ack.
  task automatic idle(input logic [1:0] es, input logic ea, input logic pc, input logic ep);
    cyc(1'b1, 8'd0, 1'b0, 1'b0, es, ea, pc, ep);
  endtask

  // Monitor: after each posedge, compare outputs against the oldest queued expectation.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("fanSpeed", int'(mon_e.tag), int'(fan_speed), int'(mon_e.spd));
      chk("alarm", int'(mon_e.tag), int'(alarm), int'(mon_e.alm));
      if (mon_e.pchk) begin
        chk("fanPwm", int'(mon_e.tag), int'(fan_pwm), int'(mon_e.pwm));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    temperature = 8'd60;
    temp_valid  = 1'b1;
    alarm_ack   = 1'b0;

    // Reset held with a hot valid sample on the inputs.
    repeat (4) cyc(1'b0, 8'd60, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Broken run 38,38,29 then a fresh run of three 38s.
    cyc(1'b1, 8'd38, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'd38, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'd29, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'd38, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'd38, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'd38, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);

    // Hysteresis in LOW: 27 holds, 25 drops to OFF; then 43 jumps OFF->MID.
    repeat (3) smp(8'd27, 2'd1, 1'b0);
    smp(8'd25, 2'd1, 1'b0);
    smp(8'd25, 2'd1, 1'b0);
    smp(8'd25, 2'd0, 1'b0);
    smp(8'd43, 2'd0, 1'b0);
    smp(8'd43, 2'd0, 1'b0);
    smp(8'd43, 2'd2, 1'b0);

    // MID duty: after the lag, 11 high cycles in any 16 consecutive.
    repeat (2) idle(2'd2, 1'b0, 1'b0, 1'b0);
    high_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      idle(2'd2, 1'b0, 1'b0, 1'b0);
      if (fan_pwm) high_cnt++;
    end
    chk("pwm_mid_high_cycles", 0, high_cnt, 11);

    // Alarm entry, ack above exit limit ignored, ack below exit limit returns to HIGH.
    smp(8'd72, 2'd3, 1'b1);
    cyc(1'b1, 8'd67, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'd65, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1);
    // Exact T_ALARM enters; hot sample beats same-cycle ack; ack uses last sample.
    cyc(1'b1, 8'd70, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'd80, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'd0,  1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'd66, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'd0,  1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'd65, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'd0,  1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1);

    // HIGH straight down to OFF; PWM follows one edge later.
    cyc(1'b1, 8'd20, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 8'd20, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 8'd20, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    idle(2'd0, 1'b0, 1'b1, 1'b0);

    // Samples separated by invalid gaps still confirm.
    smp(8'd38, 2'd0, 1'b0);
    repeat (5) idle(2'd0, 1'b0, 1'b0, 1'b0);
    smp(8'd38, 2'd0, 1'b0);
    repeat (5) idle(2'd0, 1'b0, 1'b0, 1'b0);
    smp(8'd38, 2'd1, 1'b0);

    // Partial run toward MID, then reset discards it.
    smp(8'd45, 2'd1, 1'b0);
    smp(8'd45, 2'd1, 1'b0);
    cyc(1'b0, 8'd45, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("async_rst_speed", 0, int'(fan_speed), 0);
    chk("async_rst_alarm", 0, int'(alarm), 0);
    chk("async_rst_pwm", 0, int'(fan_pwm), 0);
    cyc(1'b0, 8'd45, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'd45, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    smp(8'd45, 2'd0, 1'b0);
    smp(8'd45, 2'd2, 1'b0);
    idle(2'd2, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    chk("scoreboard_drain", 0, exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
